// File: rtl/CorePack.sv
// Shared core types.
//   imm_op_enum : immediate-generator format select driven by the control sequencer.
package CorePack;

  typedef enum logic [2:0] {
    IMM0   = 3'd0,
    I_IMM  = 3'd1,
    S_IMM  = 3'd2,
    B_IMM  = 3'd3,
    U_IMM  = 3'd4,
    UJ_IMM = 3'd5
  } imm_op_enum;

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the control sequencer and the instruction/data memories.
//   imem_req/imem_ack/imem_rdata : instruction fetch port (req held until ack, rdata valid with ack)
//   dmem_req/dmem_we/dmem_ack    : data access port (req held until ack, we=1 for store)
// master = sequencer side, slave = memory side.
interface mc_ctrl_if;

  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );

endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB for RV64I, halting on
// illegal opcodes or memory ack timeouts.
// Ports:
//   clk, rstn            : clock, async active-low reset
//   bus (master)         : imem/dmem request/ack handshakes (req/we decoded from state)
//   ir                   : latched instruction
//   immgen_op            : immediate format select
//   alu_a_sel, alu_b_sel : ALU operand selects (pc/rs1, imm/rs2)
//   br_taken             : branch comparator result, sampled in EXEC
//   rf_we, wb_sel        : register write strobe and writeback source
//   pc_we, pc_sel        : PC update strobe and next-PC source
//   state                : debug state encoding
//   illegal, timeout     : sticky halt causes
module mc_ctrl
  import CorePack::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstn,
  mc_ctrl_if.master        bus,
  output logic [31:0]      ir,
  output imm_op_enum       immgen_op,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  input  logic             br_taken,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ir_d;
  imm_op_enum       immgen_op_d, dec_imm;
  logic             alu_a_sel_d, alu_b_sel_d, dec_a, dec_b, dec_legal;
  logic [1:0]       wb_sel_d, dec_wb, pc_sel_d;
  logic             rf_we_d, pc_we_d, illegal_d, timeout_d;
  logic [6:0]       opc;

  assign opc   = ir[6:0];
  assign state = state_q;

  // Handshake requests follow the state directly so they drop with an async reset.
  assign bus.imem_req = (state_q == S_FETCH);
  assign bus.dmem_req = (state_q == S_MEM);
  assign bus.dmem_we  = (state_q == S_MEM) && (opc == OPC_STORE);

  // Opcode classification into immediate format and datapath selects.
  always_comb begin
    dec_legal = 1'b1;
    dec_imm   = IMM0;
    dec_a     = 1'b0;
    dec_b     = 1'b1;
    dec_wb    = 2'b00;
    case (opc)
      OPC_OP_IMM, OPC_OP_IMM32: dec_imm = I_IMM;
      OPC_LOAD:   begin dec_imm = I_IMM;  dec_wb = 2'b01; end
      OPC_JALR:   begin dec_imm = I_IMM;  dec_wb = 2'b10; end
      OPC_STORE:  dec_imm = S_IMM;
      OPC_BRANCH: begin dec_imm = B_IMM;  dec_b  = 1'b0;  end
      OPC_LUI:    begin dec_imm = U_IMM;  dec_wb = 2'b11; end
      OPC_AUIPC:  begin dec_imm = U_IMM;  dec_a  = 1'b1;  end
      OPC_JAL:    begin dec_imm = UJ_IMM; dec_wb = 2'b10; end
      OPC_OP, OPC_OP32: dec_b = 1'b0;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_d        = ir;
    immgen_op_d = immgen_op;
    alu_a_sel_d = alu_a_sel;
    alu_b_sel_d = alu_b_sel;
    wb_sel_d    = wb_sel;
    rf_we_d     = 1'b0;
    pc_we_d     = 1'b0;
    pc_sel_d    = 2'b00;
    illegal_d   = illegal;
    timeout_d   = timeout;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        // An ack on the last allowed wait cycle still completes normally.
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          immgen_op_d = dec_imm;
          alu_a_sel_d = dec_a;
          alu_b_sel_d = dec_b;
          wb_sel_d    = dec_wb;
          state_d     = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        if (opc == OPC_BRANCH) begin
          pc_we_d  = 1'b1;
          pc_sel_d = br_taken ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
          cnt_d    = '0;
        end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (opc == OPC_STORE) begin
            pc_we_d = 1'b1;
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we_d  = 1'b1;
        pc_we_d  = 1'b1;
        pc_sel_d = (opc == OPC_JAL)  ? 2'b01 :
                   (opc == OPC_JALR) ? 2'b10 : 2'b00;
        state_d  = S_FETCH;
        cnt_d    = '0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ir        <= '0;
      immgen_op <= IMM0;
      alu_a_sel <= 1'b0;
      alu_b_sel <= 1'b0;
      wb_sel    <= 2'b00;
      rf_we     <= 1'b0;
      pc_we     <= 1'b0;
      pc_sel    <= 2'b00;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ir        <= ir_d;
      immgen_op <= immgen_op_d;
      alu_a_sel <= alu_a_sel_d;
      alu_b_sel <= alu_b_sel_d;
      wb_sel    <= wb_sel_d;
      rf_we     <= rf_we_d;
      pc_we     <= pc_we_d;
      pc_sel    <= pc_sel_d;
      illegal   <= illegal_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases plus random instruction streams
// compared against a per-instruction transaction model.
module tb_mc_ctrl;
  import CorePack::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] ir;
  imm_op_enum  immgen_op;
  logic        alu_a_sel, alu_b_sel, rf_we, pc_we, illegal, timeout;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  state;

  mc_ctrl_if bus();

  mc_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .ir        (ir),
    .immgen_op (immgen_op),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .br_taken  (br_taken),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .state     (state),
    .illegal   (illegal),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit aborted  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Instruction classes as the architecture describes them.
  typedef enum {K_ALU, K_BR, K_LD, K_ST, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_e;

  typedef struct {
    kind_e      kind;
    imm_op_enum imm;
  } cls_t;

  function automatic cls_t classify(input logic [6:0] opc);
    cls_t c;
    c.kind = K_BAD;
    c.imm  = IMM0;
    case (opc)
      7'b0010011, 7'b0011011: begin c.kind = K_ALU;   c.imm = I_IMM;  end
      7'b0000011:             begin c.kind = K_LD;    c.imm = I_IMM;  end
      7'b1100111:             begin c.kind = K_JALR;  c.imm = I_IMM;  end
      7'b0100011:             begin c.kind = K_ST;    c.imm = S_IMM;  end
      7'b1100011:             begin c.kind = K_BR;    c.imm = B_IMM;  end
      7'b0110111:             begin c.kind = K_LUI;   c.imm = U_IMM;  end
      7'b0010111:             begin c.kind = K_AUIPC; c.imm = U_IMM;  end
      7'b1101111:             begin c.kind = K_JAL;   c.imm = UJ_IMM; end
      7'b0110011, 7'b0111011: begin c.kind = K_ALU;   c.imm = IMM0;   end
      default: ;
    endcase
    return c;
  endfunction

  // Drives one legal instruction from a FETCH cycle to the next FETCH cycle and
  // checks the transaction. tkmode: 0/1 force br_taken, 2 random.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input int tkmode, input string nm);
    cls_t       c;
    int         k, rf_n, pc_n, dm_n, both_n, lat;
    logic [1:0] psel, wbs, exp_psel, exp_wb;
    logic       dwe, tk, done, exp_b;
    c = classify(instr[6:0]);
    rf_n = 0; pc_n = 0; dm_n = 0; both_n = 0;
    psel = 2'b00; wbs = 2'b00; dwe = 1'b0; tk = 1'b0; done = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      bus.imem_ack   = (i == fw);
      bus.imem_rdata = instr;
      br_taken       = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom();
    k = 1;
    while (!done && k < 30) begin
      if (rf_we) begin rf_n++; wbs = wb_sel; end
      if (pc_we) begin pc_n++; psel = pc_sel; end
      if (bus.dmem_req) begin dm_n++; dwe = bus.dmem_we; end
      if (bus.imem_req && bus.dmem_req) both_n++;
      if (bus.imem_req) done = 1'b1;
      else begin
        bus.dmem_ack = bus.dmem_req && (dm_n == mw + 1);
        br_taken = (tkmode == 2) ? 1'($urandom_range(0, 1)) : 1'(tkmode);
        if (k == 2) tk = br_taken;
        @(negedge clk);
        k++;
      end
    end
    bus.dmem_ack = 1'b0;
    if (!done) aborted = 1'b1;

    case (c.kind)
      K_BR:    lat = 3;
      K_ST:    lat = 4 + mw;
      K_LD:    lat = 5 + mw;
      default: lat = 4;
    endcase
    exp_psel = (c.kind == K_BR)   ? {1'b0, tk} :
               (c.kind == K_JAL)  ? 2'b01 :
               (c.kind == K_JALR) ? 2'b10 : 2'b00;
    exp_wb   = (c.kind == K_LD) ? 2'b01 :
               (c.kind == K_JAL || c.kind == K_JALR) ? 2'b10 :
               (c.kind == K_LUI) ? 2'b11 : 2'b00;
    exp_b    = !(c.imm == IMM0 || c.kind == K_BR);

    check({nm, ".latency"}, 64'(k), 64'(lat));
    check({nm, ".rf_we_n"}, 64'(rf_n), 64'((c.kind == K_BR || c.kind == K_ST) ? 0 : 1));
    check({nm, ".pc_we_n"}, 64'(pc_n), 64'(1));
    check({nm, ".pc_sel"}, 64'(psel), 64'(exp_psel));
    check({nm, ".wb_at_rf"}, 64'(wbs), 64'((rf_n > 0) ? exp_wb : 2'b00));
    check({nm, ".dmem_cyc"}, 64'(dm_n), 64'((c.kind == K_LD || c.kind == K_ST) ? mw + 1 : 0));
    check({nm, ".dmem_we"}, 64'(dwe), 64'(c.kind == K_ST));
    check({nm, ".req_overlap"}, 64'(both_n), 64'(0));
    check({nm, ".ir"}, 64'(ir), 64'(instr));
    check({nm, ".immgen_op"}, 64'(immgen_op), 64'(c.imm));
    check({nm, ".alu_a_sel"}, 64'(alu_a_sel), 64'(c.kind == K_AUIPC));
    check({nm, ".alu_b_sel"}, 64'(alu_b_sel), 64'(exp_b));
    check({nm, ".wb_sel"}, 64'(wb_sel), 64'(exp_wb));
    check({nm, ".flags"}, 64'({illegal, timeout}), 64'(0));
  endtask

  // Holds reset for 3 cycles, releases it and returns in the first FETCH cycle.
  task automatic reset_dut();
    rstn = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    br_taken = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel.state_idle", 64'(state), 64'(0));
    check("rel.no_imem_req", 64'(bus.imem_req), 64'(0));
    @(negedge clk);
    check("rel.first_fetch", 64'({state, bus.imem_req}), 64'({3'd1, 1'b1}));
  endtask

  logic [6:0] opcs [11] = '{7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
                            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                            7'b1101111, 7'b0110011, 7'b0111011};

  initial begin
    int         n;
    logic [31:0] r;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0;

    // Reset values while rstn is held low.
    repeat (3) @(negedge clk);
    check("rst.state", 64'(state), 64'(0));
    check("rst.ir", 64'(ir), 64'(0));
    check("rst.immgen_op", 64'(immgen_op), 64'(IMM0));
    check("rst.selects", 64'({alu_a_sel, alu_b_sel, wb_sel, pc_sel}), 64'(0));
    check("rst.strobes", 64'({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, pc_we}), 64'(0));
    check("rst.flags", 64'({illegal, timeout}), 64'(0));
    reset_dut();

    // Directed instructions.
    run_instr(32'h0050_0093, 0, 0, 2, "addi");
    run_instr(32'h0000_0463, 0, 0, 1, "beq_t");
    run_instr(32'h0000_0463, 1, 0, 0, "beq_nt");
    run_instr(32'h0000_a103, 0, 3, 2, "lw_wait3");
    run_instr(32'h0011_2023, 2, 1, 2, "sw");
    run_instr(32'h0080_00ef, 0, 0, 2, "jal");
    run_instr(32'h0050_0093, 3, 0, 2, "fetch_ack_last");

    // Random instruction stream with random wait states up to the limit.
    for (int i = 0; i < 60 && !aborted; i++) begin
      r = $urandom();
      r[6:0] = opcs[$urandom_range(0, 10)];
      run_instr(r, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)), 2, "rand");
    end

    // Illegal opcode halts, stays quiet, and the async reset clears the flag.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("ill.state", 64'(state), 64'(6));
    check("ill.flag", 64'(illegal), 64'(1));
    n = 0;
    repeat (20) begin
      if (bus.imem_req || rf_we || pc_we) n++;
      @(negedge clk);
    end
    check("ill.quiet", 64'(n), 64'(0));
    #2 rstn = 1'b0;
    #1;
    check("ill.rst_clear", 64'({state, illegal}), 64'(0));
    reset_dut();

    // Fetch with no ack halts after TMO wait cycles.
    n = 0;
    repeat (TMO + 2) begin
      if (bus.imem_req) n++;
      @(negedge clk);
    end
    check("ftmo.req_cycles", 64'(n), 64'(TMO));
    check("ftmo.halt", 64'({state, timeout}), 64'({3'd6, 1'b1}));
    reset_dut();

    // Load whose data ack never arrives halts after TMO MEM cycles.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_a103;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n = 0;
    repeat (TMO + 4) begin
      if (bus.dmem_req) n++;
      @(negedge clk);
    end
    check("mtmo.req_cycles", 64'(n), 64'(TMO));
    check("mtmo.halt", 64'({state, timeout}), 64'({3'd6, 1'b1}));
    reset_dut();

    // Reset asserted during MEM drops the request without waiting for a clock.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0011_2023;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst.in_mem", 64'({bus.dmem_req, bus.dmem_we}), 64'(2'b11));
    #2 rstn = 1'b0;
    #1;
    check("mrst.req_drop", 64'({bus.dmem_req, bus.dmem_we, bus.imem_req}), 64'(0));
    check("mrst.state", 64'(state), 64'(0));
    reset_dut();
    run_instr(32'h0000_0463, 0, 0, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the single-port core datapath. It fetches an instruction over a request/acknowledge memory port and latches it into the instruction register. It then drives the `immgen_op` selector of the immediate generator together with the ALU, writeback, PC and data-memory controls. It steps each RV64I instruction through FETCH/DECODE/EXEC/MEM/WB and halts on illegal opcodes or memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait-state cycles in FETCH or MEM without an ack before halting (range 1..255).
- `clk` in 1: core clock.
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `imem_req` out 1: instruction fetch request. Held until `imem_ack`.
- `imem_ack` in 1: fetch done; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction.
- `ir` out 32: latched instruction. `ir[31:7]` feeds the immediate generator; remaining decode fields go to the ALU and register file.
- `immgen_op` out `CorePack::imm_op_enum`: immediate format select (IMM0, I_IMM, S_IMM, B_IMM, U_IMM, UJ_IMM).
- `alu_a_sel` out 1: ALU operand A; 0 = rs1, 1 = pc.
- `alu_b_sel` out 1: ALU operand B; 0 = rs2, 1 = imm.
- `br_taken` in 1: branch comparator result. Sampled in EXEC only.
- `dmem_req` out 1: data memory request. Held until `dmem_ack`.
- `dmem_we` out 1: 1 = store; valid while `dmem_req` is 1.
- `dmem_ack` in 1: data access done.
- `rf_we` out 1: register file write strobe (one-cycle pulse).
- `wb_sel` out 2: writeback source; 00 ALU, 01 memory, 10 pc+4, 11 imm.
- `pc_we` out 1: PC update strobe (one-cycle pulse).
- `pc_sel` out 2: next PC; 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1.
- `state` out 3: debug encoding; IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6.
- `illegal` out 1: sticky; unsupported opcode seen.
- `timeout` out 1: sticky; ack not received within `TIMEOUT_CYCLES`.

## Operation
- Decode from `ir[6:0]`:
  - 0010011, 0011011, 0000011, 1100111 → I_IMM
  - 0100011 → S_IMM
  - 1100011 → B_IMM
  - 0110111, 0010111 → U_IMM
  - 1101111 → UJ_IMM
  - 0110011, 0111011 → IMM0
  - anything else → illegal
- State transitions:
  - IDLE: entered on reset; goes to FETCH unconditionally on the next clock.
  - FETCH: `imem_req`=1. On `imem_ack`: `ir` ← `imem_rdata`, go to DECODE.
  - DECODE: register `immgen_op`, `alu_a_sel`, `alu_b_sel`, `wb_sel` for the instruction class. Illegal opcode → HALT and set `illegal`. Otherwise → EXEC.
  - EXEC: branch → `pc_we`=1, `pc_sel` = `br_taken` ? 01 : 00, then FETCH. Load/store → MEM. All others → WB.
  - MEM: `dmem_req`=1 and `dmem_we` = store. On `dmem_ack`: load → WB; store → `pc_we`=1 with `pc_sel`=00, then FETCH.
  - WB: `rf_we`=1 and `pc_we`=1, then FETCH. `pc_sel` is 01 for JAL, 10 for JALR, 00 otherwise.
  - HALT: absorbing until reset. All requests and strobes are 0.
- Per-class select values:
  - `alu_a_sel`=1 for AUIPC only.
  - `alu_b_sel`=1 for every class except IMM0 and branch.
  - `wb_sel`: 01 load; 10 JAL/JALR; 11 LUI; 00 otherwise.
- Hold rules:
  - `immgen_op` and the select outputs hold from DECODE until the next DECODE.
  - `ir` changes only on a FETCH ack.
- Timeout counter:
  - 8-bit; cleared on entry to FETCH or MEM; increments each wait cycle without an ack.
  - When it reaches `TIMEOUT_CYCLES` → HALT and set `timeout`.
  - An ack arriving in the same cycle as the limit wins: normal transition, no timeout.

## Timing
- Reset values (asynchronous, while `rstn`=0):
  - `state`=IDLE, `ir`=0, `immgen_op`=IMM0.
  - All selects = 0.
  - All req/we/strobes = 0.
  - `illegal`=0, `timeout`=0.
- Reset mid-operation: `imem_req`/`dmem_req` drop combinationally with `rstn`; the pending access is abandoned.
- First `imem_req` appears in the second clock edge cycle after `rstn` rises (IDLE lasts one cycle).
- Latency, counted from the FETCH cycle that receives an ack:
  - Branch: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles, plus MEM wait cycles.
  - Load: 5 cycles, plus MEM wait cycles.
- `rf_we` and `pc_we` are never high for more than one cycle per instruction.
- `rf_we` never asserts for stores or branches.
- `imem_req` and `dmem_req` are never high in the same cycle.
- All outputs except `imem_req`, `dmem_req` and `dmem_we` are registered. Those three are decoded from `state`.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles → all outputs at their reset values with `state`=0. Release → IDLE for 1 cycle, then `imem_req`=1.
- ADDI `0x00500093`, ack in first FETCH cycle → `immgen_op`=I_IMM and `alu_b_sel`=1 from DECODE. In WB: `rf_we`=1, `pc_we`=1, `pc_sel`=00, `wb_sel`=00. Next FETCH follows 4 cycles after the ack cycle.
- BEQ `0x00000463`:
  - with `br_taken`=1 → `immgen_op`=B_IMM; EXEC has `pc_we`=1, `pc_sel`=01; `rf_we` stays 0.
  - repeat with `br_taken`=0 → `pc_sel`=00.
- LW `0x0000a103` with `dmem_ack` delayed 3 cycles → `dmem_req`=1 for 4 cycles with `dmem_we`=0. Then WB has `wb_sel`=01, `rf_we`=1. Also: SW `0x00112023` → `dmem_we`=1, `immgen_op`=S_IMM, no `rf_we`.
- JAL `0x008000ef` → UJ_IMM, `wb_sel`=10, `pc_sel`=01. Illegal `0x00000000` → HALT with `illegal`=1 and no further `imem_req` for 20 cycles.
- `TIMEOUT_CYCLES`=4 with no `imem_ack` → HALT after 4 wait cycles, `timeout`=1. Ack on the 4th wait cycle → no timeout. Assert `rstn`=0 during MEM → `dmem_req` drops immediately and sticky flags clear.
